// File: rtl/fpu_pkg.sv
// Shared FPU types: decoder signal bundle, opcode/funct5 constants, default latencies
// and the single-precision FPU decoder used by the issue stage.
package fpu_pkg;

   localparam int unsigned FPU_DEF_TAG_W    = 5;
   localparam int unsigned FPU_DEF_FMA_LAT  = 4;
   localparam int unsigned FPU_DEF_FAST_LAT = 2;

   localparam logic [6:0] FPU_OPC_OP_FP = 7'b1010011;
   localparam logic [6:0] FPU_OPC_MADD  = 7'b1000011;
   localparam logic [6:0] FPU_OPC_MSUB  = 7'b1000111;
   localparam logic [6:0] FPU_OPC_NMSUB = 7'b1001011;
   localparam logic [6:0] FPU_OPC_NMADD = 7'b1001111;

   localparam logic [4:0] FPU_F5_ADD   = 5'b00000;
   localparam logic [4:0] FPU_F5_SUB   = 5'b00001;
   localparam logic [4:0] FPU_F5_MUL   = 5'b00010;
   localparam logic [4:0] FPU_F5_DIV   = 5'b00011;
   localparam logic [4:0] FPU_F5_SGNJ  = 5'b00100;
   localparam logic [4:0] FPU_F5_MINMX = 5'b00101;
   localparam logic [4:0] FPU_F5_CVTFF = 5'b01000;
   localparam logic [4:0] FPU_F5_SQRT  = 5'b01011;
   localparam logic [4:0] FPU_F5_CMP   = 5'b10100;
   localparam logic [4:0] FPU_F5_CVTFI = 5'b11000;
   localparam logic [4:0] FPU_F5_CVTIF = 5'b11010;
   localparam logic [4:0] FPU_F5_MVXF  = 5'b11100;
   localparam logic [4:0] FPU_F5_MVFX  = 5'b11110;

   typedef struct packed {
      logic wen;
      logic ren1;
      logic ren2;
      logic ren3;
      logic swap12;
      logic swap23;
      logic single_in;
      logic single_out;
      logic fromint;
      logic toint;
      logic fastpipe;
      logic fma;
      logic div;
      logic sqrt;
      logic wflags;
   } fpu_sigs_t;

   typedef enum logic [1:0] {
      ROUTE_DS,
      ROUTE_FMA,
      ROUTE_FAST,
      ROUTE_INT
   } fpu_route_t;

   function automatic fpu_sigs_t fpu_decode(input logic [31:0] inst);
      fpu_sigs_t s;
      logic [6:0] opc;
      logic       sp;
      s   = '0;
      opc = inst[6:0];
      sp  = (inst[26:25] == 2'b00);
      if (opc == FPU_OPC_MADD || opc == FPU_OPC_MSUB ||
          opc == FPU_OPC_NMSUB || opc == FPU_OPC_NMADD) begin
         s.wen = 1'b1; s.ren1 = 1'b1; s.ren2 = 1'b1; s.ren3 = 1'b1;
         s.fma = 1'b1; s.wflags = 1'b1;
         s.single_in = sp; s.single_out = sp;
      end else if (opc == FPU_OPC_OP_FP) begin
         s.single_in  = sp;
         s.single_out = sp;
         case (inst[31:27])
            FPU_F5_ADD, FPU_F5_SUB: begin
               s.wen = 1'b1; s.ren1 = 1'b1; s.ren2 = 1'b1; s.swap23 = 1'b1;
               s.fma = 1'b1; s.wflags = 1'b1;
            end
            FPU_F5_MUL: begin
               s.wen = 1'b1; s.ren1 = 1'b1; s.ren2 = 1'b1; s.fma = 1'b1; s.wflags = 1'b1;
            end
            FPU_F5_DIV: begin
               s.wen = 1'b1; s.ren1 = 1'b1; s.ren2 = 1'b1; s.div = 1'b1; s.wflags = 1'b1;
            end
            FPU_F5_SQRT: begin
               s.wen = 1'b1; s.ren1 = 1'b1; s.sqrt = 1'b1; s.wflags = 1'b1;
            end
            FPU_F5_SGNJ: begin
               s.wen = 1'b1; s.ren1 = 1'b1; s.ren2 = 1'b1; s.fastpipe = 1'b1;
            end
            FPU_F5_MINMX: begin
               s.wen = 1'b1; s.ren1 = 1'b1; s.ren2 = 1'b1; s.fastpipe = 1'b1; s.wflags = 1'b1;
            end
            FPU_F5_CVTFF: begin
               s.wen = 1'b1; s.ren1 = 1'b1; s.fastpipe = 1'b1; s.wflags = 1'b1;
            end
            FPU_F5_CMP: begin
               s.ren1 = 1'b1; s.ren2 = 1'b1; s.toint = 1'b1; s.wflags = 1'b1;
            end
            FPU_F5_CVTFI: begin
               s.ren1 = 1'b1; s.toint = 1'b1; s.wflags = 1'b1;
            end
            FPU_F5_MVXF: begin
               s.ren1 = 1'b1; s.toint = 1'b1;
            end
            FPU_F5_CVTIF: begin
               s.wen = 1'b1; s.swap12 = 1'b1; s.fromint = 1'b1; s.wflags = 1'b1;
            end
            FPU_F5_MVFX: begin
               s.wen = 1'b1; s.swap12 = 1'b1; s.fromint = 1'b1;
            end
            default: s = '0;
         endcase
      end
      return s;
   endfunction

endpackage

// File: rtl/fpu_issue_skid.sv
// Two-entry FIFO holding {inst, tag} in front of the FP issue logic; flush empties it.
module fpu_issue_skid #(
   parameter int unsigned W = 37
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_flush,
   input  logic         i_enq_valid,
   input  logic [W-1:0] i_enq_data,
   output logic         o_enq_ready,
   input  logic         i_deq,
   output logic         o_deq_valid,
   output logic [W-1:0] o_deq_data
);

   logic [W-1:0] r_mem [2];
   logic         r_wr_ptr;
   logic         r_rd_ptr;
   logic [1:0]   r_count;
   logic         w_enq;
   logic         w_deq;

   assign o_enq_ready = ~r_count[1];
   assign o_deq_valid = (r_count != 2'd0);
   assign o_deq_data  = r_mem[r_rd_ptr];
   assign w_enq       = i_enq_valid & o_enq_ready & ~i_flush;
   assign w_deq       = i_deq & o_deq_valid & ~i_flush;

   always_ff @(posedge i_clk) begin
      if (w_enq) r_mem[r_wr_ptr] <= i_enq_data;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else if (i_flush) begin
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_enq) r_wr_ptr <= ~r_wr_ptr;
         if (w_deq) r_rd_ptr <= ~r_rd_ptr;
         case ({w_enq, w_deq})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/fpu_issue_stage.sv
// FP issue stage: skid queue, head decode, in-order routing to FMA/fast/div-sqrt/int
// consumers, and the writeback slot reservation shifter for the fixed-latency pipes.
module fpu_issue_stage
   import fpu_pkg::*;
#(
   parameter int unsigned TAG_W    = FPU_DEF_TAG_W,
   parameter int unsigned FMA_LAT  = FPU_DEF_FMA_LAT,
   parameter int unsigned FAST_LAT = FPU_DEF_FAST_LAT
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               io_req_valid,
   output logic               io_req_ready,
   input  logic [31:0]        io_req_inst,
   input  logic [TAG_W-1:0]   io_req_tag,
   input  logic               io_flush,
   output logic               io_fma_valid,
   output logic               io_fast_valid,
   output logic               io_ds_valid,
   input  logic               io_ds_ready,
   output logic               io_int_valid,
   output logic [31:0]        io_issue_inst,
   output logic [TAG_W-1:0]   io_issue_tag,
   output logic [14:0]        io_issue_sigs,
   output logic [FMA_LAT-1:0] io_wb_resv
);

   logic [FMA_LAT-1:0]  r_resv;
   logic [FMA_LAT-1:0]  w_resv_sh;
   logic [FMA_LAT-1:0]  w_resv_new;
   logic                w_head_valid;
   logic [31+TAG_W:0]   w_head_data;
   fpu_sigs_t           w_sigs;
   fpu_route_t          w_route;
   logic                w_stall;
   logic                w_go;

   fpu_issue_skid #(
      .W (32 + TAG_W)
   ) u_skid (
      .i_clk       (clock),
      .i_rst_n     (reset),
      .i_flush     (io_flush),
      .i_enq_valid (io_req_valid),
      .i_enq_data  ({io_req_inst, io_req_tag}),
      .o_enq_ready (io_req_ready),
      .i_deq       (w_go),
      .o_deq_valid (w_head_valid),
      .o_deq_data  (w_head_data)
   );

   assign io_issue_inst = w_head_data[31+TAG_W:TAG_W];
   assign io_issue_tag  = w_head_data[TAG_W-1:0];
   assign w_sigs        = fpu_decode(io_issue_inst);
   assign io_issue_sigs = w_sigs;
   assign w_resv_sh     = r_resv >> 1;

   // Stall is judged against the shifted vector: that is what the slot will look like
   // on the cycle this issue's reservation lands.
   always_comb begin
      w_route = ROUTE_INT;
      if (w_sigs.div | w_sigs.sqrt) w_route = ROUTE_DS;
      else if (w_sigs.fma)          w_route = ROUTE_FMA;
      else if (w_sigs.fastpipe)     w_route = ROUTE_FAST;

      w_stall = 1'b0;
      case (w_route)
         ROUTE_DS:   w_stall = ~io_ds_ready;
         ROUTE_FAST: w_stall = w_resv_sh[FAST_LAT-1];
         ROUTE_INT:  w_stall = w_sigs.fromint & w_resv_sh[FAST_LAT-1];
         default:    w_stall = 1'b0;
      endcase
   end

   assign w_go          = w_head_valid & ~io_flush & ~w_stall;
   assign io_ds_valid   = w_go & (w_route == ROUTE_DS);
   assign io_fma_valid  = w_go & (w_route == ROUTE_FMA);
   assign io_fast_valid = w_go & (w_route == ROUTE_FAST);
   assign io_int_valid  = w_go & (w_route == ROUTE_INT);

   always_comb begin
      w_resv_new = '0;
      if (io_fma_valid) w_resv_new[FMA_LAT-1] = 1'b1;
      if (io_fast_valid | (io_int_valid & w_sigs.fromint)) w_resv_new[FAST_LAT-1] = 1'b1;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) r_resv <= '0;
      else        r_resv <= w_resv_sh | w_resv_new;
   end

   assign io_wb_resv = r_resv;

endmodule
